// File: rtl/op1_operand_collector_fp32.sv
// op1_operand_collector_fp32: double-buffered collector grouping an FP32 word stream into a,b,c,d operands.
// Optional Inf/NaN group rejection when FP32_OPERAND_CHECK_EN is defined.
module op1_operand_collector_fp32 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      in_data,
  input  logic             in_STB,
  output logic             in_BUSY,
  input  logic             in_clear,
  output logic [31:0]      input_a,
  output logic [31:0]      input_b,
  output logic [31:0]      input_c,
  output logic [31:0]      input_d,
  output logic             op1_input_STB,
  input  logic             op1_BUSY,
  output logic [CNT_W-1:0] groups_issued,
  output logic             err_STB
);
  localparam logic [1:0] IDLE = 2'd0, OFFER = 2'd1, HOLD = 2'd2;
  logic [31:0]      r_bank [2][4];
  logic [1:0]       r_valid;
  logic [1:0]       r_idx;
  logic             r_wb;
  logic             r_rb;
  logic [1:0]       r_state;
  logic             r_stb;
  logic [31:0]      r_a, r_b, r_c, r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_acc;
  logic             w_last;
  logic             w_bad;
  assign in_BUSY = r_valid[r_wb];
  assign w_acc = in_STB & ~in_BUSY & ~in_clear;
  assign w_last = w_acc & (r_idx == 2'd3);
`ifdef FP32_OPERAND_CHECK_EN
  assign w_bad = (&r_bank[r_wb][0][30:23]) | (&r_bank[r_wb][1][30:23]) |
                 (&r_bank[r_wb][2][30:23]) | (&in_data[30:23]);
`else
  assign w_bad = 1'b0;
`endif
  // Rejected groups leave the bank invalid and the write bank in place, so it is simply refilled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 2'b00;
      r_idx   <= 2'd0;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_state <= IDLE;
      r_stb   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_last & w_bad;
      if (in_clear) begin
        r_idx <= 2'd0;
      end else if (w_acc) begin
        r_bank[r_wb][r_idx] <= in_data;
        r_idx <= r_idx + 2'd1;
        if (w_last && !w_bad) begin
          r_valid[r_wb] <= 1'b1;
          r_wb <= ~r_wb;
        end
      end
      case (r_state)
        IDLE: if (r_valid[r_rb]) begin
          r_a     <= r_bank[r_rb][0];
          r_b     <= r_bank[r_rb][1];
          r_c     <= r_bank[r_rb][2];
          r_d     <= r_bank[r_rb][3];
          r_stb   <= 1'b1;
          r_state <= OFFER;
        end
        OFFER: if (!op1_BUSY) begin
          r_stb   <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          r_state <= HOLD;
        end
        // The unit re-reads c and d after accepting, so the bank stays owned until it goes idle.
        HOLD: if (!op1_BUSY) begin
          r_valid[r_rb] <= 1'b0;
          r_rb    <= ~r_rb;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign input_a       = r_a;
  assign input_b       = r_b;
  assign input_c       = r_c;
  assign input_d       = r_d;
  assign op1_input_STB = r_stb;
  assign groups_issued = r_cnt;
  assign err_STB       = r_err;
endmodule
